// File: rtl/mc_main_controller.sv
// Multicycle MIPS-subset main controller.
// Moore FSM that walks each instruction through fetch, decode, execute,
// memory and writeback, driving the ALU operation code and every datapath
// enable. The only combinational input path is zero -> pc_en, which
// resolves beq in the cycle the ALU compares the two registers.
module mc_main_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [CNT_W-1:0] retired
);

  // Instruction opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0]).
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // B operand selects.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  // PC source selects.
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JMP    = 4'd9,
    S_IEXE   = 4'd10,
    S_IWB    = 4'd11
  } state_e;

  // All datapath controls for one state, kept together so a state's
  // output set is built and registered as a single value.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_out;
  logic [CNT_W-1:0] retired_q;
  logic       retire;
  logic       state_legal;

  // True for the R-type function codes the datapath implements.
  function automatic logic funct_supported(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  // ALU operation for a supported R-type function code.
  function automatic logic [2:0] rtype_alu_op(input logic [5:0] fn);
    logic [2:0] op;
    op = ALU_ADD;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Output set of a state; anything not named for a state stays 0.
  function automatic ctrl_t ctrl_for(input state_e s, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_write  = 1'b1;
        c.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        c.alu_src_b = SRCB_IMM4;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_IEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_REXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = rtype_alu_op(fn);
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_SUB;
        c.branch    = 1'b1;
        c.pc_src    = PCSRC_OUT;
      end
      S_JMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_JUMP;
      end
      S_IWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state decode; unused encodings recover to FETCH.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_supported(funct) ? S_REXE : S_FETCH;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_IEXE;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_REXE:   state_d = S_RWB;
      S_IEXE:   state_d = S_IWB;
      S_MEMWB, S_MEMWR, S_RWB, S_BEQ, S_JMP, S_IWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // The last state of every legal instruction retires it, taken or not.
  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                  (state_q == S_RWB)   || (state_q == S_BEQ)   ||
                  (state_q == S_JMP)   || (state_q == S_IWB);

  // State, registered outputs for the state being entered, and the retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_for(S_FETCH, 6'b000000);
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d, funct);
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // An unused encoding can only come from an upset; it drives nothing
  // for its single cycle before recovering to FETCH.
  assign state_legal = (state_q <= S_IWB);
  assign ctrl_out    = state_legal ? ctrl_q : '0;

  assign pc_en      = ctrl_out.pc_write | (ctrl_out.branch & zero);
  assign pc_src     = ctrl_out.pc_src;
  assign i_or_d     = ctrl_out.i_or_d;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_write  = ctrl_out.mem_write;
  assign ir_write   = ctrl_out.ir_write;
  assign reg_dst    = ctrl_out.reg_dst;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign reg_write  = ctrl_out.reg_write;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign retired    = retired_q;

endmodule
